// File: rtl/irq_requester_pkg.sv
// rtl/irq_requester_pkg.sv - shared FSM encoding and vector defaults for irq_requester
package irq_requester_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INT_REQ = 3'd1,
    NMI_REQ = 3'd2,
    INT_SVC = 3'd3,
    NMI_SVC = 3'd4
  } irqState_t;

  localparam int         DEF_VEC_W    = 8;
  localparam logic [7:0] DEF_VEC_BASE = 8'h80;

endpackage

// File: rtl/irq_prio_enc.sv
// rtl/irq_prio_enc.sv - lowest-index-wins priority encoder for request lines
module irq_prio_enc #(
  parameter int NUM_IRQ = 8,
  parameter int ID_W    = 3
) (
  input  logic [NUM_IRQ-1:0] req,
  output logic [ID_W-1:0]    id,
  output logic               valid
);

  // Scan from the top down so the lowest set index is the last one written
  always_comb begin
    id    = '0;
    valid = |req;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) id = ID_W'(i);
    end
  end

endmodule

// File: rtl/irq_requester.sv
// rtl/irq_requester.sv - device-side INT/NMI requester with INA/INTD handshake (IRQ_MASK_EN adds a mask register)
module irq_requester
  import irq_requester_pkg::*;
#(
  parameter int               NUM_IRQ  = 8,
  parameter int               VEC_W    = DEF_VEC_W,
  parameter logic [VEC_W-1:0] VEC_BASE = VEC_W'(DEF_VEC_BASE)
) (
  input  logic               clk,
  input  logic               rstN,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               nmiReq,
  input  logic               INA,
  input  logic               eoi,
`ifdef IRQ_MASK_EN
  input  logic               maskWe,
  input  logic [NUM_IRQ-1:0] maskIn,
`endif
  output logic               INT,
  output logic               NMI,
  output logic               INTD,
  output logic [VEC_W-1:0]   intVector,
  output logic [NUM_IRQ-1:0] pending
);

  localparam int ID_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  irqState_t          state, stateNext;
  logic [NUM_IRQ-1:0] irqPrev;
  logic               nmiPrev;
  logic               nmiPend;
  logic               nested;
  logic [ID_W-1:0]    curId;
  logic [NUM_IRQ-1:0] enabled;
  logic [ID_W-1:0]    winId;
  logic               winValid;
  logic               ackInt, ackNmi, latchId, setNested, clrNested;
  logic [NUM_IRQ-1:0] clrMask;

`ifdef IRQ_MASK_EN
  logic [NUM_IRQ-1:0] mask;

  // Mask register; reset enables every line
  always_ff @(posedge clk) begin
    if (!rstN)       mask <= '1;
    else if (maskWe) mask <= maskIn;
  end

  assign enabled = pending & mask;
`else
  assign enabled = pending;
`endif

  irq_prio_enc #(
    .NUM_IRQ(NUM_IRQ),
    .ID_W   (ID_W)
  ) uPrio (
    .req  (enabled),
    .id   (winId),
    .valid(winValid)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rstN) state <= IDLE;
    else       state <= stateNext;
  end

  // Next-state logic; the winner id is latched on entry so a mask change cannot retract an open request
  always_comb begin
    stateNext = state;
    ackInt    = 1'b0;
    ackNmi    = 1'b0;
    latchId   = 1'b0;
    setNested = 1'b0;
    clrNested = 1'b0;
    case (state)
      IDLE: begin
        if (nmiPend) begin
          stateNext = NMI_REQ;
        end else if (winValid) begin
          stateNext = INT_REQ;
          latchId   = 1'b1;
        end
      end
      INT_REQ: begin
        if (INA) begin
          stateNext = INT_SVC;
          ackInt    = 1'b1;
        end else if (nmiPend) begin
          stateNext = NMI_REQ;
        end
      end
      NMI_REQ: begin
        if (INA) begin
          stateNext = NMI_SVC;
          ackNmi    = 1'b1;
        end
      end
      INT_SVC: begin
        if (eoi) begin
          stateNext = IDLE;
        end else if (nmiPend) begin
          stateNext = NMI_REQ;
          setNested = 1'b1;
        end
      end
      NMI_SVC: begin
        if (eoi) begin
          if (nested) begin
            stateNext = INT_SVC;
            clrNested = 1'b1;
          end else begin
            stateNext = IDLE;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Outputs decoded from registered state so they never glitch toward the Controller
  always_comb begin
    INT  = (state == INT_REQ);
    NMI  = (state == NMI_REQ);
    INTD = (state == INT_SVC) || (state == NMI_SVC) || ((state == NMI_REQ) && nested);
  end

  assign clrMask = ackInt ? (NUM_IRQ'(1) << curId) : '0;

  // Edge capture, pending bookkeeping and vector; a new edge beats a same-cycle clear
  always_ff @(posedge clk) begin
    irqPrev <= irq;
    nmiPrev <= nmiReq;
    if (!rstN) begin
      pending   <= '0;
      nmiPend   <= 1'b0;
      nested    <= 1'b0;
      curId     <= '0;
      intVector <= '0;
    end else begin
      pending <= (pending & ~clrMask) | (irq & ~irqPrev);
      nmiPend <= (nmiPend & ~ackNmi) | (nmiReq & ~nmiPrev);
      if (latchId) curId <= winId;
      if (setNested)      nested <= 1'b1;
      else if (clrNested) nested <= 1'b0;
      if (ackInt)      intVector <= VEC_BASE + VEC_W'(curId);
      else if (ackNmi) intVector <= VEC_BASE + VEC_W'(NUM_IRQ);
    end
  end

endmodule

// File: tb/tb_irq_requester.sv
// tb/tb_irq_requester.sv - directed self-checking bench for irq_requester (mask steps need IRQ_MASK_EN)
module tb_irq_requester;

  logic       clk = 1'b0;
  logic       rstN;
  logic [7:0] irq;
  logic       nmiReq;
  logic       INA;
  logic       eoi;
  logic       maskWe;
  logic [7:0] maskIn;
  logic       INT;
  logic       NMI;
  logic       INTD;
  logic [7:0] intVector;
  logic [7:0] pending;

  int nCmp = 0;
  int nErr = 0;

  irq_requester #(
    .NUM_IRQ (8),
    .VEC_W   (8),
    .VEC_BASE(8'h80)
  ) dut (
    .clk      (clk),
    .rstN     (rstN),
    .irq      (irq),
    .nmiReq   (nmiReq),
    .INA      (INA),
    .eoi      (eoi),
`ifdef IRQ_MASK_EN
    .maskWe   (maskWe),
    .maskIn   (maskIn),
`endif
    .INT      (INT),
    .NMI      (NMI),
    .INTD     (INTD),
    .intVector(intVector),
    .pending  (pending)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkOut(input string tag, input logic i, input logic n, input logic d);
    check({tag, ".INT"}, 32'(INT), 32'(i));
    check({tag, ".NMI"}, 32'(NMI), 32'(n));
    check({tag, ".INTD"}, 32'(INTD), 32'(d));
  endtask

  initial begin
    rstN = 1'b0; irq = 8'h00; nmiReq = 1'b0; INA = 1'b0; eoi = 1'b0;
    maskWe = 1'b0; maskIn = 8'hFF;
    tick(); tick();
    rstN = 1'b1;
    checkOut("reset", 1'b0, 1'b0, 1'b0);
    check("reset.vec", 32'(intVector), 32'h00);
    check("reset.pend", 32'(pending), 32'h00);

    // Two lines rise together; line 2 served first, then line 5
    irq = 8'h24;
    tick();
    check("t1.pend", 32'(pending), 32'h24);
    check("t1.INT0", 32'(INT), 32'd0);
    tick();
    check("t1.INT1", 32'(INT), 32'd1);
    tick(); tick(); tick();
    INA = 1'b1; tick(); INA = 1'b0;
    checkOut("t1.ack", 1'b0, 1'b0, 1'b1);
    check("t1.vec", 32'(intVector), 32'h82);
    check("t1.pendAck", 32'(pending), 32'h20);
    eoi = 1'b1; tick(); eoi = 1'b0;
    checkOut("t1.eoi", 1'b0, 1'b0, 1'b0);
    tick();
    check("t1.reINT", 32'(INT), 32'd1);
    INA = 1'b1; tick(); INA = 1'b0;
    check("t1.vec2", 32'(intVector), 32'h85);
    check("t1.pend2", 32'(pending), 32'h00);
    eoi = 1'b1; tick(); eoi = 1'b0;
    irq = 8'h00; tick();
    checkOut("t1.idle", 1'b0, 1'b0, 1'b0);

    // NMI overtakes an unacknowledged INT_REQ for line 3
    irq = 8'h08;
    tick(); tick();
    check("t2.INT", 32'(INT), 32'd1);
    nmiReq = 1'b1;
    tick();
    checkOut("t2.nmiEdge", 1'b1, 1'b0, 1'b0);
    tick();
    checkOut("t2.nmiReq", 1'b0, 1'b1, 1'b0);
    INA = 1'b1; tick(); INA = 1'b0;
    checkOut("t2.nmiSvc", 1'b0, 1'b0, 1'b1);
    check("t2.vec", 32'(intVector), 32'h88);
    check("t2.pendKept", 32'(pending), 32'h08);
    eoi = 1'b1; tick(); eoi = 1'b0;
    checkOut("t2.eoi", 1'b0, 1'b0, 1'b0);
    tick();
    check("t2.reINT", 32'(INT), 32'd1);
    INA = 1'b1; tick(); INA = 1'b0;
    check("t2.vec3", 32'(intVector), 32'h83);
    eoi = 1'b1; tick(); eoi = 1'b0;
    irq = 8'h00; nmiReq = 1'b0; tick();

    // Nested NMI during service of line 1
    irq = 8'h02;
    tick(); tick();
    INA = 1'b1; tick(); INA = 1'b0;
    check("t3.vec1", 32'(intVector), 32'h81);
    nmiReq = 1'b1;
    tick();
    checkOut("t3.svc", 1'b0, 1'b0, 1'b1);
    tick();
    checkOut("t3.nestReq", 1'b0, 1'b1, 1'b1);
    INA = 1'b1; tick(); INA = 1'b0;
    checkOut("t3.nmiSvc", 1'b0, 1'b0, 1'b1);
    check("t3.vec", 32'(intVector), 32'h88);
    eoi = 1'b1; tick(); eoi = 1'b0;
    checkOut("t3.backSvc", 1'b0, 1'b0, 1'b1);
    tick();
    check("t3.stillSvc", 32'(INTD), 32'd1);
    eoi = 1'b1; tick(); eoi = 1'b0;
    checkOut("t3.done", 1'b0, 1'b0, 1'b0);
    irq = 8'h00; nmiReq = 1'b0; tick();

    // Ignored inputs: INA in IDLE, eoi in INT_REQ
    INA = 1'b1; tick(); INA = 1'b0;
    checkOut("t6.inaIdle", 1'b0, 1'b0, 1'b0);
    check("t6.vecKept", 32'(intVector), 32'h88);
    irq = 8'h10;
    tick(); tick();
    eoi = 1'b1; tick(); eoi = 1'b0;
    checkOut("t6.eoiReq", 1'b1, 1'b0, 1'b0);
    INA = 1'b1; tick(); INA = 1'b0;
    check("t6.vec", 32'(intVector), 32'h84);
    eoi = 1'b1; tick(); eoi = 1'b0;

    // Reset mid-service with irq[2] held high
    irq = 8'h04;
    tick(); tick();
    INA = 1'b1; tick(); INA = 1'b0;
    check("t5.vec", 32'(intVector), 32'h82);
    rstN = 1'b0; tick(); rstN = 1'b1;
    checkOut("t5.rst", 1'b0, 1'b0, 1'b0);
    check("t5.rstVec", 32'(intVector), 32'h00);
    check("t5.rstPend", 32'(pending), 32'h00);
    tick(); tick(); tick();
    check("t5.noINT", 32'(INT), 32'd0);
    check("t5.noPend", 32'(pending), 32'h00);
    irq = 8'h00; tick();
    irq = 8'h04; tick();
    check("t5.pendNew", 32'(pending), 32'h04);
    tick();
    check("t5.INTnew", 32'(INT), 32'd1);
    INA = 1'b1; tick(); INA = 1'b0;
    eoi = 1'b1; tick(); eoi = 1'b0;
    irq = 8'h00; tick();

`ifdef IRQ_MASK_EN
    // Masked line is held pending and served once unmasked
    maskIn = 8'hFE; maskWe = 1'b1; tick(); maskWe = 1'b0;
    irq = 8'h01; tick();
    check("t4.pend", 32'(pending), 32'h01);
    tick(); tick();
    check("t4.masked", 32'(INT), 32'd0);
    maskIn = 8'hFF; maskWe = 1'b1; tick(); maskWe = 1'b0;
    tick();
    check("t4.unmasked", 32'(INT), 32'd1);
    INA = 1'b1; tick(); INA = 1'b0;
    check("t4.vec", 32'(intVector), 32'h80);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule

// File: doc/irq_requester.md
# irq_requester

Interrupt-request unit on the device side of the CPU Controller's interrupt handshake. Collects up to NUM_IRQ device interrupt lines and one non-maskable source, arbitrates them, and drives INT/NMI toward the Controller. Completes the handshake when the Controller returns INA, then presents a vector and holds INTD while the handler runs. It sits between the peripheral bus and the Controller's INT, NMI, INTD and INA pins.

## Interface
- NUM_IRQ, 8, number of maskable request lines (1..16)
- VEC_W, 8, vector width
- VEC_BASE, 8'h80, vector of line 0; line i → VEC_BASE+i, NMI → VEC_BASE+NUM_IRQ (all mod 2^VEC_W)
- clk  in  1  clock; all state changes on rising edge
- rstN  in  1  synchronous, active-low reset
- irq  in  NUM_IRQ  device requests, rising-edge sensitive
- nmiReq  in  1  non-maskable request, rising-edge sensitive
- INA  in  1  interrupt acknowledge from Controller
- eoi  in  1  end-of-interrupt pulse (handler return)
- maskWe  in  1  mask write strobe (IRQ_MASK_EN only)
- maskIn  in  NUM_IRQ  mask write data, 1 = enabled (IRQ_MASK_EN only)
- INT  out  1  maskable request to Controller
- NMI  out  1  non-maskable request to Controller
- INTD  out  1  interrupt in service / further maskable requests disabled
- intVector  out  VEC_W  vector of the last acknowledged request
- pending  out  NUM_IRQ  pending maskable requests (debug)

## Operation
- Edge detect: irqPrev/nmiPrev registers. A rising edge sets pending[i] or nmiPend at that clock edge.
- Arbitration: lowest-index pending & enabled line wins. NMI beats all maskable lines.
- FSM states: IDLE, INT_REQ, NMI_REQ, INT_SVC, NMI_SVC, plus a nested flag.
- IDLE:
  - nmiPend → NMI_REQ.
  - Otherwise any enabled pending line → INT_REQ; the winner id is latched.
- INT_REQ:
  - INA → INT_SVC. Clear pending[id], intVector ← VEC_BASE+id.
  - nmiPend and no INA → NMI_REQ. The pending bit is retained.
- NMI_REQ: INA → NMI_SVC. Clear nmiPend, intVector ← VEC_BASE+NUM_IRQ.
- INT_SVC:
  - eoi → IDLE.
  - nmiPend → NMI_REQ with nested=1. NMI preempts.
- NMI_SVC: eoi → INT_SVC if nested (clear nested), else IDLE.
- Outputs, all registered:
  - INT=1 only in INT_REQ.
  - NMI=1 only in NMI_REQ.
  - INTD=1 in INT_SVC, NMI_SVC, and in NMI_REQ when nested.
- INT and NMI are never high together.
- Ignored inputs:
  - INA in any state other than INT_REQ or NMI_REQ.
  - eoi outside the *_SVC states.
- Same-edge set and clear of one pending bit: the set wins and the new request is kept.
- Masked pending bits are held. They are presented once unmasked.
- A mask change never cancels an INT_REQ already in progress.

## Timing
- irq[i] rises at edge k → pending[i]=1 after k → INT=1 after edge k+1. Latency is 2 cycles.
- INA sampled high at edge m:
  - INT/NMI=0, INTD=1 and intVector valid after edge m.
  - The next request can be raised no earlier than eoi+1 edge.
- eoi at edge e: INTD=0 after e (non-nested). A waiting request raises INT after e+1.
- Reset (rstN=0 at an edge), from any state including mid-handshake:
  - state=IDLE, INT=0, NMI=0, INTD=0, intVector=0, pending=0, nmiPend=0, nested=0, mask=all ones.
  - irqPrev and nmiPrev are loaded with the current inputs, so lines already high do not register as edges.

## Configuration
- IRQ_MASK_EN defined:
  - Adds a mask register, written from maskIn when maskWe=1, effective the next edge.
  - Arbitration uses pending & mask.
- IRQ_MASK_EN undefined:
  - maskWe/maskIn ports are absent.
  - All lines are always enabled.

## Structure
- Shared package holds:
  - the FSM state encoding (3-bit enum: IDLE, INT_REQ, NMI_REQ, INT_SVC, NMI_SVC)
  - default VEC_BASE/VEC_W constants
- One natural sub-module: irq_prio_enc. It is a combinational lowest-index priority encoder that outputs id and valid, parameterized by NUM_IRQ.

## Test plan
- irq=8'h00→8'h24 at edge 10, INA at edge 15 → INT=1 after edge 11; intVector=8'h82, INTD=1 after edge 15; pending=8'h20; eoi at edge 20 → INT=1 again after edge 21; INA → intVector=8'h85.
- INT_REQ for line 3, nmiReq rises → NMI=1, INT=0 after 2 edges; INA → intVector=8'h88; eoi → IDLE, then INT re-raised for line 3.
- Line 1 in service, nmiReq rises → NMI with INTD=1; INA, eoi → back in INT_SVC (INTD=1); second eoi → INTD=0.
- IRQ_MASK_EN: maskIn=8'hFE, irq[0] edge → no INT, pending=8'h01; maskIn=8'hFF → INT after 1 edge, vector 8'h80.
- rstN low during INT_SVC with irq[2] held high → all outputs 0 after the edge; no INT after release until irq[2] falls and rises again.
- INA pulse in IDLE and eoi in INT_REQ → no state or output change.
